// File: rtl/key_expansion_pkg.sv
// Shared AES key-schedule constants, state encoding and the rcon xtime helper.
package key_expansion_pkg;

   localparam int unsigned AES_KEY_WIDTH  = 128;
   localparam int unsigned AES_NUM_ROUNDS = 10;
   localparam logic [7:0]  RCON_INIT      = 8'h01;
   localparam logic [7:0]  RCON_POLY      = 8'h1B;

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } ks_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup; shared with the subBytes stage.
module aes_sbox (
   input  logic [7:0] plain,
   output logic [7:0] subst
);

   // Row 0 of the table sits in the most-significant bits.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   always_comb begin
      subst = SBOX_TABLE[(8'd255 - plain) * 8 +: 8];
   end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one cipher key in, round keys 0..10 out over valid/ready.
module key_expansion
   import key_expansion_pkg::*;
#(
   parameter int unsigned KEY_WIDTH  = AES_KEY_WIDTH,
   parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 key_valid_in,
   output logic                 key_ready_out,
   input  logic [KEY_WIDTH-1:0] key_in,
   output logic                 round_key_valid_out,
   input  logic                 round_key_ready_in,
   output logic [KEY_WIDTH-1:0] round_key_out,
   output logic [3:0]           round_num_out,
   output logic                 last_round_out
);

   if (KEY_WIDTH != 128) begin : gen_width_check
      $error("key_expansion supports KEY_WIDTH == 128 only");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   ks_state_e            state_q, state_d;
   logic [KEY_WIDTH-1:0] key_q, key_d;
   logic [3:0]           round_q, round_d;
   logic [7:0]           rcon_q, rcon_d;

   logic [31:0] w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

   assign w0  = key_q[127:96];
   assign w1  = key_q[95:64];
   assign w2  = key_q[63:32];
   assign w3  = key_q[31:0];
   assign rot = {w3[23:0], w3[31:24]};

   for (genvar g = 0; g < 4; g++) begin : gen_subword
      aes_sbox u_sbox (
         .plain (rot[8*g +: 8]),
         .subst (sub[8*g +: 8])
      );
   end

   assign t  = sub ^ {rcon_q, 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   always_comb begin
      state_d             = state_q;
      key_d               = key_q;
      round_d             = round_q;
      rcon_d              = rcon_q;
      key_ready_out       = (state_q == IDLE);
      round_key_valid_out = (state_q == EXPAND);
      if (state_q == IDLE) begin
         if (key_valid_in) begin
            key_d   = key_in;
            round_d = 4'd0;
            rcon_d  = RCON_INIT;
            state_d = EXPAND;
         end
      end else if (round_key_ready_in) begin
         if (round_q == LAST_ROUND) begin
            state_d = IDLE;
         end else begin
            key_d   = {n0, n1, n2, n3};
            round_d = round_q + 4'd1;
            rcon_d  = xtime(rcon_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= 4'd0;
         rcon_q  <= RCON_INIT;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         rcon_q  <= rcon_d;
      end
   end

   assign round_key_out  = key_q;
   assign round_num_out  = round_q;
   assign last_round_out = round_key_valid_out && (round_q == LAST_ROUND);

endmodule

// File: tb/tb_key_expansion.sv
// Scoreboard bench for key_expansion using FIPS-197 and "Thats my Kung Fu" key vectors.
module tb_key_expansion;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_valid_in = 1'b0;
   logic         key_ready_out;
   logic [127:0] key_in = '0;
   logic         round_key_valid_out;
   logic         round_key_ready_in = 1'b1;
   logic [127:0] round_key_out;
   logic [3:0]   round_num_out;
   logic         last_round_out;

   key_expansion dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .key_valid_in        (key_valid_in),
      .key_ready_out       (key_ready_out),
      .key_in              (key_in),
      .round_key_valid_out (round_key_valid_out),
      .round_key_ready_in  (round_key_ready_in),
      .round_key_out       (round_key_out),
      .round_num_out       (round_num_out),
      .last_round_out      (last_round_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   rnum;
      logic [127:0] rk;
      bit           known;
   } exp_t;

   exp_t sb[$];
   int   n_compared   = 0;
   int   n_mismatched = 0;
   int   vcnt         = 0;

   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KF_KEY   = 128'h5468617473206d79204b756e67204675;

   logic [127:0] fips_rk [0:10] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Only rounds 0, 1 and 10 of the second key have reference values.
   task automatic push_seq(input bit use_fips);
      exp_t e;
      for (int r = 0; r <= 10; r++) begin
         e.rnum = 4'(r);
         if (use_fips) begin
            e.rk    = fips_rk[r];
            e.known = 1'b1;
         end else begin
            e.rk    = (r == 0) ? KF_KEY :
                      (r == 1) ? 128'he232fcf191129188b159e4e6d679a293 :
                                 128'h28fddef86da4244accc0a4fe3b316f26;
            e.known = (r == 0) || (r == 1) || (r == 10);
         end
         sb.push_back(e);
      end
   endtask

   task automatic send_key(input logic [127:0] k, input bit use_fips);
      int c = 0;
      while (!key_ready_out && c < 100) begin
         @(posedge clk); #1; c++;
      end
      check_eq("send_ready", key_ready_out, 1'b1);
      push_seq(use_fips);
      key_in       = k;
      key_valid_in = 1'b1;
      @(posedge clk); #1;
      key_valid_in = 1'b0;
   endtask

   task automatic drain(input string tag);
      int c = 0;
      while ((sb.size() != 0 || !key_ready_out) && c < 300) begin
         @(posedge clk); #1; c++;
      end
      check_eq(tag, (sb.size() == 0) && key_ready_out, 1'b1);
   endtask

   task automatic wait_round(input logic [3:0] r, input string tag);
      int c = 0;
      while (!(round_key_valid_out && round_num_out == r) && c < 50) begin
         @(posedge clk); #1; c++;
      end
      check_eq(tag, round_num_out, r);
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_kready"}, key_ready_out, 1'b1);
      check_eq({tag, "_valid"}, round_key_valid_out, 1'b0);
      check_eq({tag, "_rk"}, round_key_out, 128'h0);
      check_eq({tag, "_rnum"}, round_num_out, 4'd0);
      check_eq({tag, "_last"}, last_round_out, 1'b0);
   endtask

   // Scoreboard: a transfer is observed on the negedge before the edge that takes it.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && round_key_valid_out) vcnt++;
      if (rst_n && round_key_valid_out && round_key_ready_in) begin
         check_eq("sb_nonempty", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("rnum", round_num_out, e.rnum);
            if (e.known) check_eq("round_key", round_key_out, e.rk);
            check_eq("last_round", last_round_out, e.rnum == 4'd10);
         end
      end
   end

   initial begin
      // Reset and idle
      #23;
      check_reset_vals("rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check_reset_vals("idle");

      // FIPS key, no backpressure
      vcnt = 0;
      send_key(FIPS_KEY, 1'b1);
      drain("fips_drain");
      check_eq("fips_valid_cycles", vcnt, 11);
      check_eq("fips_ready_after", key_ready_out, 1'b1);

      // Second reference key
      send_key(KF_KEY, 1'b0);
      drain("kf_drain");

      // Backpressure on round 4
      send_key(FIPS_KEY, 1'b1);
      wait_round(4'd4, "bp_reach_r4");
      round_key_ready_in = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("bp_hold_rk", round_key_out, fips_rk[4]);
         check_eq("bp_hold_rnum", round_num_out, 4'd4);
      end
      @(posedge clk); #1;
      round_key_ready_in = 1'b1;
      drain("bp_drain");

      // Key offered during EXPAND is ignored
      send_key(FIPS_KEY, 1'b1);
      @(posedge clk); #1;
      key_in       = KF_KEY;
      key_valid_in = 1'b1;
      check_eq("busy_kready", key_ready_out, 1'b0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      key_valid_in = 1'b0;
      drain("busy_drain");
      send_key(KF_KEY, 1'b0);
      drain("busy_retry_drain");

      // Asynchronous reset during round 6
      send_key(FIPS_KEY, 1'b1);
      wait_round(4'd6, "rst_reach_r6");
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      sb.delete();
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      send_key(FIPS_KEY, 1'b1);
      drain("post_rst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
